// File: rtl/store_merge_unit.sv
// store_merge_unit: merges SB/SH/SW/SD stores into aligned 64-bit memory words via read-modify-write.
module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [63:0] address,
  input  logic [63:0] storeData,
  output logic [63:0] memAddress,
  output logic        memRead,
  output logic        memWrite,
  output logic [63:0] memWriteData,
  input  logic [63:0] memReadData,
  input  logic        memReady,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] wid;
  logic [2:0] off;
  logic [63:0] sdata, rmask, merged;
  logic [7:0] bm;
  logic err, accept, bad;
  assign accept = state == IDLE && start && opcode == 7'b0100011;
  assign bad = funct3[2] | (funct3[1:0] == 2'd1 & address[0]) |
               (funct3[1:0] == 2'd2 & |address[1:0]) | (funct3[1:0] == 2'd3 & |address[2:0]);
  // byte-lane enables of the latched store, expanded to a bit mask
  assign bm = (wid == 2'd0 ? 8'h01 : wid == 2'd1 ? 8'h03 : 8'h0f) << off;
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign rmask[8*i +: 8] = {8{bm[i]}};
  end
  assign merged = (memReadData & ~rmask) | ((sdata << {off, 3'b000}) & rmask);
  assign busy = state != IDLE;
  assign memRead = state == READ;
  assign memWrite = state == WRITE;
  assign done = state == RESP;
  assign error = done & err;
  always_comb begin
    state_nx = state == IDLE  ? (accept ? (bad ? RESP : funct3[1:0] == 2'd3 ? WRITE : READ) : IDLE) :
               state == READ  ? (memReady ? WRITE : READ) :
               state == WRITE ? (memReady ? RESP : WRITE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      memAddress <= '0;
      memWriteData <= '0;
      wid <= '0;
      off <= '0;
      sdata <= '0;
      err <= 1'b0;
    end else if (accept) begin
      memAddress <= {address[63:3], 3'b000};
      memWriteData <= storeData;
      wid <= funct3[1:0];
      off <= address[2:0];
      sdata <= storeData;
      err <= bad;
    end else if (state == READ && memReady) begin
      memWriteData <= merged;
    end
  end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: directed store vectors with hand-computed merged words and latencies.
module tb_store_merge_unit;
  logic clk = 0, reset = 1, start = 0, memReady = 1;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic [63:0] address = 0, storeData = 0, memReadData = 0;
  logic [63:0] memAddress, memWriteData;
  logic memRead, memWrite, busy, done, error;
  int checks = 0, failures = 0;
  int wr_cnt = 0, rd_cnt = 0, wc_cnt = 0, both = 0, dn_cnt = 0, unstable = 0;
  logic [63:0] wr_addr = 0, wr_data = 0, p_addr = 0, p_wd = 0;
  logic p_busy = 0, p_wr = 0;

  store_merge_unit dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
    .address(address), .storeData(storeData), .memAddress(memAddress), .memRead(memRead),
    .memWrite(memWrite), .memWriteData(memWriteData), .memReadData(memReadData),
    .memReady(memReady), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWrite && memReady) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr <= memAddress;
      wr_data <= memWriteData;
    end
    if (memRead) rd_cnt <= rd_cnt + 1;
    if (memWrite) wc_cnt <= wc_cnt + 1;
    if (memRead && memWrite) both <= both + 1;
    if (done) dn_cnt <= dn_cnt + 1;
    if (busy && p_busy && memAddress != p_addr) unstable <= unstable + 1;
    if (memWrite && p_wr && memWriteData != p_wd) unstable <= unstable + 1;
    p_busy <= busy;
    p_addr <= memAddress;
    p_wr <= memWrite;
    p_wd <= memWriteData;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int n, input int rl, input int wl);
    return !(n <= rl) && !(n > rl + 1 && n <= rl + 1 + wl);
  endfunction

  task automatic do_store(input string tag, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] rd, input int rl, input int wl,
                          input int lat, input logic exp_err, input int exp_rd, input int exp_wr,
                          input logic [63:0] exp_addr, input logic [63:0] exp_data);
    int n, w0, r0, c0, b0, u0;
    w0 = wr_cnt; r0 = rd_cnt; c0 = wc_cnt; b0 = both; u0 = unstable;
    start = 1; opcode = 7'b0100011; funct3 = f; address = a; storeData = d; memReadData = rd;
    step();
    n = 1;
    address = ~a; storeData = ~d; funct3 = 3'b011;
    memReady = rdy(n, rl, wl);
    while (!done && n < 40) begin
      start = n[0];
      step();
      n++;
      memReady = rdy(n, rl, wl);
    end
    start = 0;
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_err"}, error, exp_err);
    step();
    memReady = 1;
    chk({tag, "_reads"}, rd_cnt - r0, exp_rd);
    chk({tag, "_wcyc"}, wc_cnt - c0, exp_wr == 0 ? 0 : wl + 1);
    chk({tag, "_writes"}, wr_cnt - w0, exp_wr);
    chk({tag, "_overlap"}, both - b0, 0);
    chk({tag, "_stable"}, unstable - u0, 0);
    if (exp_wr != 0) begin
      chk({tag, "_waddr"}, wr_addr, exp_addr);
      chk({tag, "_wdata"}, wr_data, exp_data);
    end
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int w0, d0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd", memRead, 0);
    chk("rst_wr", memWrite, 0);
    chk("rst_addr", memAddress, 0);
    chk("rst_wdata", memWriteData, 0);
    reset = 0;
    start = 1; opcode = 7'b0000011; funct3 = 3'b000; address = 64'h100;
    step();
    chk("nonstore_ignored", busy, 0);
    reset = 1; opcode = 7'b0100011;
    step();
    chk("rst_over_start", busy, 0);
    reset = 0; start = 0;
    step();
    do_store("sb", 3'b000, 64'h1003, 64'hAB, 64'h1122334455667788, 0, 0, 3, 0, 1, 1,
             64'h1000, 64'h11223344AB667788);
    do_store("sh", 3'b001, 64'h2006, 64'hBEEF, 64'h0, 0, 0, 3, 0, 1, 1,
             64'h2000, 64'hBEEF000000000000);
    do_store("sw", 3'b010, 64'h2004, 64'hDEADBEEF, 64'hFFFFFFFFFFFFFFFF, 0, 0, 3, 0, 1, 1,
             64'h2000, 64'hDEADBEEFFFFFFFFF);
    do_store("sd", 3'b011, 64'h3000, 64'h0123456789ABCDEF, 64'h5555555555555555, 0, 0, 2, 0, 0, 1,
             64'h3000, 64'h0123456789ABCDEF);
    do_store("sb_lane7", 3'b000, 64'h5007, 64'hFFFFFFFFFFFFFF5A, 64'h0, 0, 0, 3, 0, 1, 1,
             64'h5000, 64'h5A00000000000000);
    do_store("sh_lane0", 3'b001, 64'h10, 64'hFFFFFFFFFFFF1234, 64'hAAAAAAAAAAAAAAAA, 0, 0, 3, 0, 1, 1,
             64'h10, 64'hAAAAAAAAAAAA1234);
    do_store("sw_mis", 3'b010, 64'h4002, 64'h1, 64'h0, 0, 0, 1, 1, 0, 0, 64'h0, 64'h0);
    do_store("f3_100", 3'b100, 64'h4000, 64'h1, 64'h0, 0, 0, 1, 1, 0, 0, 64'h0, 64'h0);
    do_store("sh_mis", 3'b001, 64'h4001, 64'h1, 64'h0, 0, 0, 1, 1, 0, 0, 64'h0, 64'h0);
    do_store("sd_mis", 3'b011, 64'h4004, 64'h1, 64'h0, 0, 0, 1, 1, 0, 0, 64'h0, 64'h0);
    do_store("sb_stall", 3'b000, 64'h8002, 64'h3C, 64'h0706050403020100, 5, 3, 11, 0, 6, 1,
             64'h8000, 64'h07060504033C0100);
    w0 = wr_cnt; d0 = dn_cnt;
    start = 1; opcode = 7'b0100011; funct3 = 3'b000; address = 64'h6001; storeData = 64'h77;
    memReadData = 64'h0; memReady = 1;
    step();
    start = 0;
    step();
    memReady = 0;
    chk("abort_wr_active", memWrite, 1);
    step();
    chk("abort_wr_held", memWrite, 1);
    reset = 1;
    step();
    reset = 0;
    chk("abort_wr_drop", memWrite, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", memAddress, 0);
    memReady = 1;
    repeat (3) step();
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_no_done", dn_cnt - d0, 0);
    do_store("sb_after_rst", 3'b000, 64'h7005, 64'hC3, 64'h0, 0, 0, 3, 0, 1, 1,
             64'h7000, 64'h0000C30000000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
